// File: rtl/writeback_stage_pipe.sv
// Writeback stage: MEM/WB register, result mux, load extract, retire count.
// Optional in-stage load alignment is enabled by defining WB_LOAD_ALIGN_EN.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid, stall,    upstream handshake; accept = in_valid & !stall & !flush
//   flush, in_ready
//   ReadData, ALUResult, PCPlus4, Rd, WbSel, MemSize, MemUnsigned,
//   ByteOffset, RegWrite                 instruction fields from the memory stage
//   WriteData, WriteReg, RegWriteOut     register-file write port
//   wb_valid, retire_count               retire pulse and retired count
module writeback_stage_pipe #(
    parameter int XLEN         = 64,
    parameter int REG_ADDR_W   = 5,
    parameter int RETIRE_CNT_W = 32,
    localparam int OFF_W       = $clog2(XLEN/8)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         ReadData,
    input  logic [XLEN-1:0]         ALUResult,
    input  logic [XLEN-1:0]         PCPlus4,
    input  logic [REG_ADDR_W-1:0]   Rd,
    input  logic [1:0]              WbSel,
    input  logic [1:0]              MemSize,
    input  logic                    MemUnsigned,
    input  logic [OFF_W-1:0]        ByteOffset,
    input  logic                    RegWrite,
    output logic [XLEN-1:0]         WriteData,
    output logic [REG_ADDR_W-1:0]   WriteReg,
    output logic                    RegWriteOut,
    output logic                    wb_valid,
    output logic [RETIRE_CNT_W-1:0] retire_count
);

    logic                    w_accept;
    logic [XLEN-1:0]         w_load;
    logic [XLEN-1:0]         w_result;

    logic                    r_valid;
    logic [XLEN-1:0]         r_wdata;
    logic [REG_ADDR_W-1:0]   r_wreg;
    logic                    r_regwrite;
    logic [RETIRE_CNT_W-1:0] r_count;

    assign in_ready = !stall;
    assign w_accept = in_valid & !stall & !flush;

`ifdef WB_LOAD_ALIGN_EN
    logic [OFF_W-1:0] w_off;
    logic [XLEN-1:0]  w_shift;
    logic [63:0]      w_ext;

    // Offset is forced to the access alignment before shifting.
    always_comb begin
        w_off = ByteOffset;
        unique case (MemSize)
            2'b00: w_off = ByteOffset;
            2'b01: w_off[0] = 1'b0;
            2'b10: w_off[1:0] = 2'b00;
            default: w_off = '0;
        endcase
    end

    assign w_shift = ReadData >> {w_off, 3'b000};

    // Extension is built at 64 bits and truncated, so for XLEN=32 the
    // word and dword cases both collapse to the full unmodified word.
    always_comb begin
        w_ext = '0;
        unique case (MemSize)
            2'b00: w_ext = {{56{~MemUnsigned & w_shift[7]}}, w_shift[7:0]};
            2'b01: w_ext = {{48{~MemUnsigned & w_shift[15]}}, w_shift[15:0]};
            2'b10: w_ext = {{32{~MemUnsigned & w_shift[31]}}, w_shift[31:0]};
            default: w_ext[XLEN-1:0] = ReadData;
        endcase
    end

    assign w_load = w_ext[XLEN-1:0];
`else
    // The memory stage already extracted the element.
    logic w_unused_load;
    assign w_unused_load = ^{MemSize, MemUnsigned, ByteOffset};
    assign w_load = ReadData;
`endif

    always_comb begin
        w_result = ALUResult;
        unique case (1'b1)
            (WbSel == 2'b01): w_result = w_load;
            (WbSel == 2'b10): w_result = PCPlus4;
            default:          w_result = ALUResult;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_wdata    <= '0;
            r_wreg     <= '0;
            r_regwrite <= 1'b0;
            r_count    <= '0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_wdata    <= w_result;
                r_wreg     <= Rd;
                r_regwrite <= RegWrite;
            end
            if (r_valid) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign WriteData    = r_wdata;
    assign WriteReg     = r_wreg;
    assign RegWriteOut  = r_valid & r_regwrite & (r_wreg != '0);
    assign wb_valid     = r_valid;
    assign retire_count = r_count;

endmodule

// File: tb/tb_writeback_stage_pipe.sv
// Directed testbench for writeback_stage_pipe.
// Each task drives one scenario and checks outputs 1 time unit after posedge.
module tb_writeback_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic        in_ready;
    logic [63:0] ReadData;
    logic [63:0] ALUResult;
    logic [63:0] PCPlus4;
    logic [4:0]  Rd;
    logic [1:0]  WbSel;
    logic [1:0]  MemSize;
    logic        MemUnsigned;
    logic [2:0]  ByteOffset;
    logic        RegWrite;
    logic [63:0] WriteData;
    logic [4:0]  WriteReg;
    logic        RegWriteOut;
    logic        wb_valid;
    logic [31:0] retire_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    writeback_stage_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
        .flush(flush), .in_ready(in_ready), .ReadData(ReadData),
        .ALUResult(ALUResult), .PCPlus4(PCPlus4), .Rd(Rd), .WbSel(WbSel),
        .MemSize(MemSize), .MemUnsigned(MemUnsigned),
        .ByteOffset(ByteOffset), .RegWrite(RegWrite),
        .WriteData(WriteData), .WriteReg(WriteReg),
        .RegWriteOut(RegWriteOut), .wb_valid(wb_valid),
        .retire_count(retire_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [63:0] alu,
                         input logic [63:0] pc, input logic [4:0] rd);
        in_valid  = 1'b1;
        WbSel     = sel;
        ALUResult = alu;
        PCPlus4   = pc;
        Rd        = rd;
        RegWrite  = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2'b00, 64'h1111, 64'h0, 5'd3);
        tick();
        total++;
        if (wb_valid !== 1'b0 || RegWriteOut !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid wb=%b we=%b exp 0 0", wb_valid, RegWriteOut);
        end
        total++;
        if (retire_count !== 32'd0 || WriteData !== 64'd0 || WriteReg !== 5'd0) begin
            bad++;
            $display("FAIL reset_regs cnt=%0d wd=%h wr=%0d exp 0", retire_count, WriteData, WriteReg);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
        idle();
        tick();
    endtask

    task automatic test_alu();
        drive(2'b00, 64'hBBBB_BBBB_BBBB_BBBB, 64'h4, 5'd7);
        tick();
        idle();
        total++;
        if (WriteData !== 64'hBBBB_BBBB_BBBB_BBBB || WriteReg !== 5'd7) begin
            bad++;
            $display("FAIL alu_data wd=%h wr=%0d exp bbbbbbbbbbbbbbbb 7", WriteData, WriteReg);
        end
        total++;
        if (RegWriteOut !== 1'b1 || wb_valid !== 1'b1) begin
            bad++;
            $display("FAIL alu_pulse we=%b wb=%b exp 1 1", RegWriteOut, wb_valid);
        end
        tick();
        total++;
        if (RegWriteOut !== 1'b0 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL alu_pulse_end we=%b wb=%b exp 0 0", RegWriteOut, wb_valid);
        end
        total++;
        if (retire_count !== 32'd1) begin
            bad++;
            $display("FAIL alu_count got=%0d exp=1", retire_count);
        end
    endtask

    task automatic test_x0();
        drive(2'b00, 64'hEEEE_EEEE_EEEE_EEEE, 64'h8, 5'd0);
        tick();
        idle();
        total++;
        if (RegWriteOut !== 1'b0 || wb_valid !== 1'b1) begin
            bad++;
            $display("FAIL x0_we we=%b wb=%b exp 0 1", RegWriteOut, wb_valid);
        end
        total++;
        if (WriteData !== 64'hEEEE_EEEE_EEEE_EEEE) begin
            bad++;
            $display("FAIL x0_data got=%h exp=eeeeeeeeeeeeeeee", WriteData);
        end
        tick();
        total++;
        if (retire_count !== 32'd2) begin
            bad++;
            $display("FAIL x0_count got=%0d exp=2", retire_count);
        end
    endtask

    task automatic test_stall_flush();
        drive(2'b00, 64'h1234, 64'h0, 5'd9);
        stall = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready got=%b exp=0", in_ready);
        end
        tick();
        total++;
        if (wb_valid !== 1'b0 || WriteData !== 64'hEEEE_EEEE_EEEE_EEEE) begin
            bad++;
            $display("FAIL stall_hold wb=%b wd=%h exp 0 eeeeeeeeeeeeeeee", wb_valid, WriteData);
        end
        stall = 1'b0;
        flush = 1'b1;
        tick();
        total++;
        if (wb_valid !== 1'b0 || WriteReg !== 5'd0) begin
            bad++;
            $display("FAIL flush_drop wb=%b wr=%0d exp 0 0", wb_valid, WriteReg);
        end
        idle();
        tick();
        total++;
        if (retire_count !== 32'd2) begin
            bad++;
            $display("FAIL flush_count got=%0d exp=2", retire_count);
        end
    endtask

    task automatic test_pc4();
        drive(2'b10, 64'h5555, 64'h1004, 5'd1);
        tick();
        idle();
        total++;
        if (WriteData !== 64'h1004 || WriteReg !== 5'd1 || RegWriteOut !== 1'b1) begin
            bad++;
            $display("FAIL pc4 wd=%h wr=%0d we=%b exp 1004 1 1", WriteData, WriteReg, RegWriteOut);
        end
        drive(2'b11, 64'h7777, 64'h2008, 5'd2);
        tick();
        idle();
        total++;
        if (WriteData !== 64'h7777) begin
            bad++;
            $display("FAIL sel11_alu got=%h exp=7777", WriteData);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals [5];
        vals[0] = 64'h10;
        vals[1] = 64'h21;
        vals[2] = 64'h32;
        vals[3] = 64'h43;
        vals[4] = 64'h54;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, vals[i], 64'h0, 5'(i + 3));
            tick();
            total++;
            if (wb_valid !== 1'b1 || WriteData !== vals[i] ||
                retire_count !== 32'(i)) begin
                bad++;
                $display("FAIL b2b_%0d wb=%b wd=%h cnt=%0d exp 1 %h %0d",
                         i, wb_valid, WriteData, retire_count, vals[i], i);
            end
        end
        idle();
        tick();
        total++;
        if (retire_count !== 32'd5 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_count cnt=%0d wb=%b exp 5 0", retire_count, wb_valid);
        end
        drive(2'b00, 64'h99, 64'h0, 5'd4);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (retire_count !== 32'd0 || RegWriteOut !== 1'b0 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset cnt=%0d we=%b wb=%b exp 0 0 0", retire_count, RegWriteOut, wb_valid);
        end
        tick();
        total++;
        if (retire_count !== 32'd0) begin
            bad++;
            $display("FAIL midreset_after got=%0d exp=0", retire_count);
        end
    endtask

    task automatic load(input logic [63:0] rdata, input logic [1:0] sz,
                        input logic uns, input logic [2:0] off,
                        input logic [63:0] exp, input string name);
        drive(2'b01, 64'hA5A5, 64'h0, 5'd5);
        ReadData    = rdata;
        MemSize     = sz;
        MemUnsigned = uns;
        ByteOffset  = off;
        tick();
        idle();
        total++;
        if (WriteData !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, WriteData, exp);
        end
    endtask

    task automatic test_load();
`ifdef WB_LOAD_ALIGN_EN
        load(64'h0000_0000_8000_0000, 2'b00, 1'b0, 3'd3, 64'hFFFF_FFFF_FFFF_FF80, "lb");
        load(64'h0000_0000_8000_0000, 2'b00, 1'b1, 3'd3, 64'h0000_0000_0000_0080, "lbu");
        load(64'h0000_0000_8000_0000, 2'b01, 1'b0, 3'd2, 64'hFFFF_FFFF_FFFF_8000, "lh");
        load(64'h0000_0000_8000_0000, 2'b01, 1'b1, 3'd3, 64'h0000_0000_0000_8000, "lhu_mask");
        load(64'h8765_4321_0000_0000, 2'b10, 1'b0, 3'd5, 64'hFFFF_FFFF_8765_4321, "lw_mask");
        load(64'h8765_4321_0000_0000, 2'b10, 1'b1, 3'd4, 64'h0000_0000_8765_4321, "lwu");
        load(64'h8765_4321_0F0E_0D0C, 2'b11, 1'b1, 3'd6, 64'h8765_4321_0F0E_0D0C, "ld");
`else
        load(64'hDEAD_BEEF_DEAD_BEEF, 2'b00, 1'b0, 3'd3, 64'hDEAD_BEEF_DEAD_BEEF, "ld_raw");
        load(64'h0000_0000_8000_0000, 2'b01, 1'b1, 3'd2, 64'h0000_0000_8000_0000, "ld_raw2");
`endif
    endtask

    initial begin
        idle();
        ReadData    = '0;
        ALUResult   = '0;
        PCPlus4     = '0;
        Rd          = '0;
        WbSel       = '0;
        MemSize     = 2'b11;
        MemUnsigned = 1'b0;
        ByteOffset  = '0;
        RegWrite    = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_x0();
        test_stall_flush();
        test_pc4();
        test_load();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
